// File: rtl/alu_pkg.sv
// Shared types for the ALU datapath and its sequencing controller.
// Instruction layout, opcode encoding, register index and controller state.
package alu_pkg;

  localparam int ALU_DATA_WIDTH  = 16;
  localparam int ALU_OP_WIDTH    = 4;
  localparam int ALU_INSTR_WIDTH = ALU_OP_WIDTH + 7 + ALU_DATA_WIDTH / 2;

  typedef logic [ALU_DATA_WIDTH-1:0] alu_data_t;
  typedef logic [1:0]                alu_reg_idx_t;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    XOR = 4'd4,
    LUI = 4'd5,
    LLI = 4'd6,
    SLL = 4'd7,
    SRL = 4'd8,
    SLA = 4'd9,
    SRA = 4'd10
  } alu_op_t;

  typedef struct packed {
    alu_op_t                       op;
    alu_reg_idx_t                  rd;
    alu_reg_idx_t                  ra;
    alu_reg_idx_t                  rb;
    logic                          imm_sel;
    logic [ALU_DATA_WIDTH/2-1:0]   imm;
  } alu_instr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } ctrl_state_t;

  // Codes above SRA (11..15) are reserved and must not write the register file.
  function automatic logic op_legal(input alu_op_t op);
    return (op <= SRA);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: arithmetic/logic ops, half-word loads and shifts by the full b value.
// Shifting by DATA_WIDTH or more gives 0, or sign fill for SRA.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  alu_op_t               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero
);

  localparam int HALF = DATA_WIDTH / 2;

  // Operation select; unknown opcodes produce zero.
  always_comb begin
    result = '0;
    case (op)
      ADD:     result = a + b;
      SUB:     result = a - b;
      AND:     result = a & b;
      OR:      result = a | b;
      XOR:     result = a ^ b;
      LUI:     result = {b[HALF-1:0], {HALF{1'b0}}};
      LLI:     result = {{HALF{1'b0}}, b[HALF-1:0]};
      SLL:     result = a << b;
      SRL:     result = a >> b;
      SLA:     result = a <<< b;
      SRA:     result = $unsigned($signed(a) >>> b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_regfile.sv
// Four-entry register file: two combinational read ports, one write port,
// synchronous active-low clear that wins over a write in the same cycle.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  we,
  input  alu_reg_idx_t          waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  alu_reg_idx_t          raddr_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  alu_reg_idx_t          raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  logic [DATA_WIDTH-1:0] mem [4];

  // Register storage with clear priority.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < 4; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end else begin
      mem[waddr] <= mem[waddr];
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller: accepts an instruction, executes it on the ALU against
// the register file, writes back and returns the result over a valid/ready stream.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = ALU_DATA_WIDTH,
  parameter int OP_WIDTH    = ALU_OP_WIDTH,
  parameter int INSTR_WIDTH = OP_WIDTH + 7 + DATA_WIDTH / 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  output logic [DATA_WIDTH-1:0]  res_data,
  output logic                   res_zero,
  output logic                   res_err,
  output logic                   res_valid,
  input  logic                   res_ready
);

  ctrl_state_t           state;
  alu_instr_t            cur;
  logic [DATA_WIDTH-1:0] ra_data;
  logic [DATA_WIDTH-1:0] rb_data;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_zero;
  logic                  legal;
  logic                  wr_en;

  assign legal = op_legal(cur.op);
  assign op_b  = cur.imm_sel ? {{(DATA_WIDTH/2){1'b0}}, cur.imm} : rb_data;
  // Reset clears the register file in the same edge, so an EXEC-cycle reset commits nothing.
  assign wr_en = (state == EXEC) && legal;

  alu_regfile #(.DATA_WIDTH(DATA_WIDTH)) u_regfile (
    .clk     (clk),
    .clr_n   (rst_n),
    .we      (wr_en),
    .waddr   (cur.rd),
    .wdata   (alu_res),
    .raddr_a (cur.ra),
    .rdata_a (ra_data),
    .raddr_b (cur.rb),
    .rdata_b (rb_data)
  );

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op     (cur.op),
    .a      (ra_data),
    .b      (op_b),
    .result (alu_res),
    .zero   (alu_zero)
  );

  // Controller FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur         <= '0;
      instr_ready <= 1'b1;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_zero    <= 1'b0;
      res_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            cur         <= alu_instr_t'(instr);
            instr_ready <= 1'b0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (legal) begin
            res_data <= alu_res;
            res_zero <= alu_zero;
            res_err  <= 1'b0;
          end else begin
            res_data <= '0;
            res_zero <= 1'b1;
            res_err  <= 1'b1;
          end
          res_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            instr_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          res_valid   <= 1'b0;
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: directed instructions push hand-computed
// responses; a monitor pops and compares on every response handshake.
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [18:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] res_data;
  logic        res_zero;
  logic        res_err;
  logic        res_valid;
  logic        res_ready = 1'b1;

  typedef struct {
    logic [15:0] d;
    logic        z;
    logic        e;
    int          id;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  alu_seq_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .res_data    (res_data),
    .res_zero    (res_zero),
    .res_err     (res_err),
    .res_valid   (res_valid),
    .res_ready   (res_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] ra, input logic [1:0] rb,
                                      input logic s, input logic [7:0] imm);
    return {op, rd, ra, rb, s, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compare each accepted response against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && res_valid && res_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_response actual=%0h/%0b/%0b required=none",
                 res_data, res_zero, res_err);
      end else begin
        e = q.pop_front();
        if (res_data !== e.d || res_zero !== e.z || res_err !== e.e) begin
          errors++;
          $display("FAIL resp_%0d actual=%0h/%0b/%0b required=%0h/%0b/%0b",
                   e.id, res_data, res_zero, res_err, e.d, e.z, e.e);
        end
      end
    end
  end

  task automatic issue(input logic [18:0] w);
    int n;
    @(posedge clk);
    #2;
    instr       = w;
    instr_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_ready && n < 60);
    if (!instr_ready) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #2;
    instr_valid = 1'b0;
  endtask

  task automatic send(input logic [18:0] w, input logic [15:0] d, input logic z,
                      input logic e, input int id);
    exp_t x;
    x.d = d; x.z = z; x.e = e; x.id = id;
    q.push_back(x);
    issue(w);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", instr_ready, 1'b1);
    check("rst_valid", res_valid, 1'b0);
    check("rst_data",  res_data, 16'h0000);
    check("rst_zero",  res_zero, 1'b0);
    check("rst_err",   res_err, 1'b0);
    @(posedge clk); #2; rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", instr_ready, 1'b1);

    // Load and compose
    send(enc(4'd6, 2'd1, 2'd0, 2'd0, 1'b1, 8'h34), 16'h0034, 1'b0, 1'b0, 1);
    send(enc(4'd5, 2'd2, 2'd0, 2'd0, 1'b1, 8'h12), 16'h1200, 1'b0, 1'b0, 2);
    send(enc(4'd3, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00), 16'h1234, 1'b0, 1'b0, 3);
    // Zero flag and wrap
    send(enc(4'd5, 2'd0, 2'd0, 2'd0, 1'b1, 8'hFF), 16'hFF00, 1'b0, 1'b0, 4);
    send(enc(4'd3, 2'd0, 2'd0, 2'd0, 1'b1, 8'hFF), 16'hFFFF, 1'b0, 1'b0, 5);
    send(enc(4'd0, 2'd0, 2'd0, 2'd0, 1'b1, 8'h01), 16'h0000, 1'b1, 1'b0, 6);
    drain();

    // Backpressure and latency on SUB: 0x0034 - 0x1234
    res_ready = 1'b0;
    send(enc(4'd1, 2'd2, 2'd1, 2'd3, 1'b0, 8'h00), 16'hEE00, 1'b0, 1'b0, 7);
    @(negedge clk);
    check("lat_exec_valid", res_valid, 1'b0);
    @(negedge clk);
    check("lat_resp_valid", res_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", res_valid, 1'b1);
      check("bp_data",  res_data, 16'hEE00);
      check("bp_ready", instr_ready, 1'b0);
    end
    @(posedge clk); #2; res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_ready", instr_ready, 1'b1);
    check("release_valid", res_valid, 1'b0);

    // Illegal opcodes leave R1 untouched
    send(enc(4'hF, 2'd1, 2'd0, 2'd0, 1'b1, 8'h55), 16'h0000, 1'b1, 1'b1, 8);
    send(enc(4'hB, 2'd1, 2'd0, 2'd0, 1'b1, 8'h77), 16'h0000, 1'b1, 1'b1, 9);
    send(enc(4'd3, 2'd3, 2'd1, 2'd1, 1'b0, 8'h00), 16'h0034, 1'b0, 1'b0, 10);

    // Shifts on R1 = 0x8001
    send(enc(4'd5, 2'd1, 2'd0, 2'd0, 1'b1, 8'h80), 16'h8000, 1'b0, 1'b0, 11);
    send(enc(4'd3, 2'd1, 2'd1, 2'd0, 1'b1, 8'h01), 16'h8001, 1'b0, 1'b0, 12);
    send(enc(4'd7, 2'd2, 2'd1, 2'd0, 1'b1, 8'd1),  16'h0002, 1'b0, 1'b0, 13);
    send(enc(4'd8, 2'd2, 2'd1, 2'd0, 1'b1, 8'd4),  16'h0800, 1'b0, 1'b0, 14);
    send(enc(4'd7, 2'd2, 2'd1, 2'd0, 1'b1, 8'd16), 16'h0000, 1'b1, 1'b0, 15);
    send(enc(4'd10, 2'd2, 2'd1, 2'd0, 1'b1, 8'd4),  16'hF800, 1'b0, 1'b0, 16);
    send(enc(4'd10, 2'd2, 2'd1, 2'd0, 1'b1, 8'd16), 16'hFFFF, 1'b0, 1'b0, 17);
    send(enc(4'd9, 2'd2, 2'd1, 2'd0, 1'b1, 8'd1),  16'h0002, 1'b0, 1'b0, 18);
    send(enc(4'd4, 2'd3, 2'd1, 2'd1, 1'b0, 8'h00), 16'h0000, 1'b1, 1'b0, 19);
    send(enc(4'd2, 2'd3, 2'd1, 2'd0, 1'b1, 8'hFF), 16'h0001, 1'b0, 1'b0, 20);
    send(enc(4'd0, 2'd3, 2'd2, 2'd1, 1'b0, 8'h00), 16'h8003, 1'b0, 1'b0, 21);
    drain();

    // Reset during EXEC drops the instruction and clears the register file
    issue(enc(4'd6, 2'd0, 2'd0, 2'd0, 1'b1, 8'hAA));
    rst_n = 1'b0;
    @(posedge clk); #2; rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", instr_ready, 1'b1);
    check("midrst_valid", res_valid, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_resp", res_valid, 1'b0);
    end
    send(enc(4'd3, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00), 16'h0000, 1'b1, 1'b0, 22);
    send(enc(4'd3, 2'd0, 2'd3, 2'd0, 1'b0, 8'h00), 16'h0000, 1'b1, 1'b0, 23);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
